audio_adc_deserializer: RTL and testbench
=========================================

# audio_adc_deserializer

Captures the WM8731 ADC serial stream (AUD_ADCDAT) in I2S format, with the codec as bit/frame-clock master (AUD_BCLK, AUD_ADCLRCK inputs), and presents each stereo frame as a parallel left/right pair on a valid/ready handshake in the CLOCK_50 domain. It is the receive-side counterpart of the sinewave DAC serializer and feeds downstream processing or a DAC loopback path.

## Interface
- DATA_WIDTH, 16: bits captured per channel, MSB first; remaining slot bits are ignored.
- clk  input  1  system clock (CLOCK_50).
- resetn  input  1  synchronous, active-low reset (KEY[0]).
- AUD_BCLK  input  1  codec bit clock, asynchronous to clk.
- AUD_ADCLRCK  input  1  codec frame clock, asynchronous to clk; low = left, high = right.
- AUD_ADCDAT  input  1  serial ADC data.
- out_left  output  DATA_WIDTH  left sample, two's complement.
- out_right  output  DATA_WIDTH  right sample.
- out_valid  output  1  frame available.
- out_ready  input  1  consumer accepts the frame.
- overrun  output  1  one-cycle pulse when a completed frame is dropped.
- frame_err  output  1  one-cycle pulse when a slot ends before DATA_WIDTH bits arrive.
- overrun_cnt  output  8  saturating overrun count (see Configuration).

## Operation
- Synchronization: BCLK, ADCLRCK, ADCDAT each pass through 2 flops. BCLK gets a third flop; rising-edge strobe = s2 & ~s3. LRCK and DAT are sampled from their s2 flops on the strobe cycle.
- States:
  - IDLE: wait for a strobe where sampled LRCK = 0 and previous sampled LRCK = 1 (left slot start), then go to SHIFT. That strobe is the I2S delay bit and is discarded.
  - SHIFT: shift one bit per strobe, MSB first, into the left or right shift register according to the slot. After DATA_WIDTH bits go to WAIT.
  - WAIT: discard bits until a strobe shows an LRCK change, then go to SHIFT for the new slot (that strobe is again the delay bit).
- In SHIFT, an LRCK change before DATA_WIDTH bits: frame_err pulses, the partial frame is discarded, and the block returns to IDLE.
- Frame complete = the DATA_WIDTH-th right-channel bit is captured.
  - If out_valid = 0, or out_valid & out_ready in the same cycle: load out_left/out_right and set out_valid = 1.
  - Otherwise: overrun pulses, the held frame is kept, and the new frame is dropped.
- Handshake: out_valid stays high until a cycle with out_valid & out_ready. out_valid clears on the next edge unless a frame loads in that same cycle, in which case it stays 1 with the new data. Outputs are stable while out_valid = 1 and not accepted.
- A resetn = 0 mid-frame aborts capture. After release the block resynchronizes via IDLE, and a partial frame never reaches the outputs.

## Timing
- Reset values: out_left = 0, out_right = 0, out_valid = 0, overrun = 0, frame_err = 0, overrun_cnt = 0, state = IDLE, all shift registers and sync flops = 0.
- Pin-to-strobe latency: 3 clk edges after AUD_BCLK rises.
- out_valid rises 1 clk after the strobe of the final right bit.
- overrun and frame_err pulse exactly 1 clk, on the same edge where out_valid would have loaded, or the edge of the offending strobe.
- Each BCLK half-period must be ≥ 3 clk periods. At the bench rate (BCLK 320 ns, 32-bit slots), a frame completes every 20.48 µs.

## Configuration
- ADC_OVERRUN_CNT_EN defined: overrun_cnt increments on each overrun pulse, saturates at 255, and clears only on reset.
- ADC_OVERRUN_CNT_EN undefined: the counter logic is omitted and overrun_cnt is tied to 0. The overrun pulse is present in both builds.

## Test plan
- Basic frame: resetn pulsed low, then left slot 0x8001 and right slot 0x7FFE (32-bit slots, BCLK 320 ns), out_ready = 1 -> out_valid one cycle with out_left = 0x8001, out_right = 0x7FFE, frame_err = 0.
- Mid-stream start: release reset partway through a right slot -> no out_valid until the next full left+right frame, and the first output equals that frame.
- Backpressure: out_ready = 0 across frames A = 0x1111/0x2222 and B = 0x3333/0x4444 -> out_valid stays high holding A, overrun pulses once at B, overrun_cnt = 1 with the macro (0 without). Raising out_ready then delivers A only.
- Accept/load collision: out_ready asserted exactly on the cycle frame C completes -> no overrun, out_valid stays 1, outputs become C.
- Short slot: LRCK toggles after 8 data bits -> frame_err pulses once, no out_valid for that frame, the next well-formed frame is delivered correctly.
- Reset mid-capture: resetn = 0 for 2 clk during the left-slot MSBs -> all outputs return to their reset values, and the first output after release is the next complete frame.

Source files
------------

// File: rtl/audio_adc_deserializer_if.sv
// rtl/audio_adc_deserializer_if.sv - parallel stereo frame handshake between the ADC deserializer and its consumer
interface audio_adc_deserializer_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] out_left;
    logic [DATA_WIDTH-1:0] out_right;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output out_left,
        output out_right,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_left,
        input  out_right,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/audio_adc_deserializer.sv
// rtl/audio_adc_deserializer.sv - WM8731 I2S ADC capture into parallel stereo frames; optional ADC_OVERRUN_CNT_EN overrun counter
module audio_adc_deserializer #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     AUD_BCLK,
    input  logic                     AUD_ADCLRCK,
    input  logic                     AUD_ADCDAT,
    audio_adc_deserializer_if.master out_if,
    output logic                     overrun,
    output logic                     frame_err,
    output logic [7:0]               overrun_cnt
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic bclk_s1, bclk_s2, bclk_s3;
    logic lrck_s1, lrck_s2;
    logic dat_s1, dat_s2;

    logic                  lrck_prev;
    logic                  slot_right;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] left_sr;
    logic [DATA_WIDTH-1:0] right_sr;

    logic strobe;
    logic lrck_smp;
    logic dat_smp;
    logic lrck_edge;
    logic left_start;
    logic last_bit;

    logic slot_start;
    logic shift_en;
    logic short_slot;
    logic frame_done;
    logic load;
    logic drop;

    // Two-flop synchronizers for all codec pins, plus a third BCLK flop for rising-edge detection
    always_ff @(posedge clk) begin
        if (!resetn) begin
            bclk_s1 <= 1'b0;
            bclk_s2 <= 1'b0;
            bclk_s3 <= 1'b0;
            lrck_s1 <= 1'b0;
            lrck_s2 <= 1'b0;
            dat_s1  <= 1'b0;
            dat_s2  <= 1'b0;
        end else begin
            bclk_s1 <= AUD_BCLK;
            bclk_s2 <= bclk_s1;
            bclk_s3 <= bclk_s2;
            lrck_s1 <= AUD_ADCLRCK;
            lrck_s2 <= lrck_s1;
            dat_s1  <= AUD_ADCDAT;
            dat_s2  <= dat_s1;
        end
    end

    assign strobe     = bclk_s2 & ~bclk_s3;
    assign lrck_smp   = lrck_s2;
    assign dat_smp    = dat_s2;
    assign lrck_edge  = lrck_smp ^ lrck_prev;
    assign left_start = ~lrck_smp & lrck_prev;
    assign last_bit   = (bit_cnt == CNT_W'(DATA_WIDTH - 1));

    // Remember the LRCK level seen on the previous bit strobe to spot slot boundaries
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lrck_prev <= 1'b0;
        end else if (strobe) begin
            lrck_prev <= lrck_smp;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: lock on a left-slot start, shift the payload, then idle out the slot padding
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (strobe && left_start) begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (strobe) begin
                    if (lrck_edge) begin
                        state_nxt = ST_IDLE;
                    end else if (last_bit) begin
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (strobe && lrck_edge) begin
                    state_nxt = ST_SHIFT;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: the delay-bit strobe opens a slot, payload strobes shift, early LRCK edges abort
    always_comb begin
        slot_start = 1'b0;
        shift_en   = 1'b0;
        short_slot = 1'b0;
        frame_done = 1'b0;
        case (state)
            ST_IDLE: begin
                slot_start = strobe & left_start;
            end
            ST_SHIFT: begin
                shift_en   = strobe & ~lrck_edge;
                short_slot = strobe & lrck_edge;
                frame_done = strobe & ~lrck_edge & last_bit & slot_right;
            end
            ST_WAIT: begin
                slot_start = strobe & lrck_edge;
            end
            default: begin
                slot_start = 1'b0;
            end
        endcase
    end

    // Slot bookkeeping: which channel is being filled and how many payload bits have arrived
    always_ff @(posedge clk) begin
        if (!resetn) begin
            slot_right <= 1'b0;
            bit_cnt    <= '0;
        end else if (slot_start) begin
            slot_right <= lrck_smp;
            bit_cnt    <= '0;
        end else if (shift_en) begin
            bit_cnt    <= bit_cnt + CNT_W'(1);
        end
    end

    // Per-channel MSB-first shift registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            left_sr  <= '0;
            right_sr <= '0;
        end else if (shift_en) begin
            if (slot_right) begin
                right_sr <= {right_sr[DATA_WIDTH-2:0], dat_smp};
            end else begin
                left_sr  <= {left_sr[DATA_WIDTH-2:0], dat_smp};
            end
        end
    end

    // A completed frame loads when the holding slot is empty or being emptied this cycle; otherwise it is dropped
    assign load = frame_done & (~out_if.out_valid | out_if.out_ready);
    assign drop = frame_done & out_if.out_valid & ~out_if.out_ready;

    // Output holding register with valid/ready handshake and single-cycle status pulses
    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_if.out_left  <= '0;
            out_if.out_right <= '0;
            out_if.out_valid <= 1'b0;
            overrun          <= 1'b0;
            frame_err        <= 1'b0;
        end else begin
            overrun   <= drop;
            frame_err <= short_slot;
            if (load) begin
                out_if.out_left  <= left_sr;
                out_if.out_right <= {right_sr[DATA_WIDTH-2:0], dat_smp};
                out_if.out_valid <= 1'b1;
            end else if (out_if.out_valid && out_if.out_ready) begin
                out_if.out_valid <= 1'b0;
            end
        end
    end

`ifdef ADC_OVERRUN_CNT_EN
    logic [7:0] overrun_cnt_q;

    // Saturating count of dropped frames, cleared only by reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            overrun_cnt_q <= 8'd0;
        end else if (drop && (overrun_cnt_q != 8'hFF)) begin
            overrun_cnt_q <= overrun_cnt_q + 8'd1;
        end
    end

    assign overrun_cnt = overrun_cnt_q;
`else
    assign overrun_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_audio_adc_deserializer.sv
// tb/tb_audio_adc_deserializer.sv - self-checking bench for the I2S ADC deserializer
module tb_audio_adc_deserializer;

    localparam int DW     = 16;
    localparam int SLOT   = 32;
    localparam int HALF_B = 160;

`ifdef ADC_OVERRUN_CNT_EN
    localparam logic [7:0] EXP_OVR_CNT = 8'd1;
`else
    localparam logic [7:0] EXP_OVR_CNT = 8'd0;
`endif

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       bclk = 1'b0;
    logic       lrck = 1'b0;
    logic       adcdat = 1'b0;
    logic       overrun;
    logic       frame_err;
    logic [7:0] overrun_cnt;

    audio_adc_deserializer_if #(.DATA_WIDTH(DW)) dif ();

    audio_adc_deserializer #(.DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .AUD_BCLK    (bclk),
        .AUD_ADCLRCK (lrck),
        .AUD_ADCDAT  (adcdat),
        .out_if      (dif),
        .overrun     (overrun),
        .frame_err   (frame_err),
        .overrun_cnt (overrun_cnt)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ovr_count = 0;
    int ferr_count = 0;
    int valid_cycles = 0;
    logic [31:0] got[$];
    logic [31:0] exp_q[$];
    logic        hold_pending = 1'b0;
    logic [31:0] held = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Consumer-side monitor: records accepted frames, counts pulses, checks holding behaviour
    always @(negedge clk) begin
        if (resetn) begin
            if (hold_pending) begin
                chk("hold_valid", 64'(dif.out_valid), 64'd1);
                chk("hold_data", 64'({dif.out_left, dif.out_right}), 64'(held));
            end
            if (dif.out_valid && dif.out_ready) got.push_back({dif.out_left, dif.out_right});
            if (overrun) ovr_count++;
            if (frame_err) ferr_count++;
            if (dif.out_valid) valid_cycles++;
            hold_pending = dif.out_valid & ~dif.out_ready;
            held = {dif.out_left, dif.out_right};
        end else begin
            hold_pending = 1'b0;
        end
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic bclk_bit(input logic lr, input logic d);
        lrck = lr;
        adcdat = d;
        #HALF_B bclk = 1'b1;
        #HALF_B bclk = 1'b0;
    endtask

    task automatic send_slot(input logic lr, input logic [15:0] data, input int nbits);
        logic d;
        for (int i = 0; i < nbits; i++) begin
            if (i >= 1 && i <= DW) d = data[DW-i];
            else d = 1'($urandom);
            bclk_bit(lr, d);
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        send_slot(1'b0, l, SLOT);
        send_slot(1'b1, r, SLOT);
    endtask

    task automatic sync_phase();
        @(posedge clk);
        #7;
    endtask

    task automatic settle();
        repeat (5) @(negedge clk);
    endtask

    initial begin
        logic [15:0] xl, xr, yl, yr, cl, cr, pl, pr;
        time t_rise;
        dif.out_ready = 1'b1;

        // Reset state
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(dif.out_valid), 64'd0);
        chk("rst_left", 64'(dif.out_left), 64'd0);
        chk("rst_right", 64'(dif.out_right), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        chk("rst_frame_err", 64'(frame_err), 64'd0);
        chk("rst_ovr_cnt", 64'(overrun_cnt), 64'd0);
        @(posedge clk);
        #1 resetn = 1'b1;

        // Basic frame
        got.delete(); valid_cycles = 0; ferr_count = 0;
        sync_phase();
        send_slot(1'b1, 16'h0, SLOT);
        send_frame(16'h8001, 16'h7FFE);
        settle();
        chk("basic_count", 64'(got.size()), 64'd1);
        if (got.size() > 0) chk("basic_data", 64'(got[0]), 64'h8001_7FFE);
        chk("basic_valid_cycles", 64'(valid_cycles), 64'd1);
        chk("basic_frame_err", 64'(ferr_count), 64'd0);

        // Mid-stream start: reset released partway through a right slot
        @(posedge clk);
        #1 resetn = 1'b0;
        xl = 16'($urandom); xr = 16'($urandom);
        sync_phase();
        fork
            begin
                send_slot(1'b0, 16'($urandom), SLOT);
                send_slot(1'b1, 16'($urandom), SLOT);
            end
            begin
                #(2 * HALF_B * SLOT + 2 * HALF_B * 10);
                resetn = 1'b1;
            end
        join
        got.delete();
        send_frame(xl, xr);
        settle();
        chk("midstart_count", 64'(got.size()), 64'd1);
        if (got.size() > 0) chk("midstart_data", 64'(got[0]), 64'({xl, xr}));

        // Backpressure: A held, B dropped with one overrun
        got.delete(); ovr_count = 0;
        @(posedge clk);
        #1 dif.out_ready = 1'b0;
        sync_phase();
        send_frame(16'h1111, 16'h2222);
        send_frame(16'h3333, 16'h4444);
        settle();
        chk("bp_valid", 64'(dif.out_valid), 64'd1);
        chk("bp_hold", 64'({dif.out_left, dif.out_right}), 64'h1111_2222);
        chk("bp_overrun_pulses", 64'(ovr_count), 64'd1);
        chk("bp_overrun_cnt", 64'(overrun_cnt), 64'(EXP_OVR_CNT));
        @(posedge clk);
        #1 dif.out_ready = 1'b1;
        settle();
        chk("bp_drain_count", 64'(got.size()), 64'd1);
        if (got.size() > 0) chk("bp_drain_data", 64'(got[0]), 64'h1111_2222);
        chk("bp_drain_valid", 64'(dif.out_valid), 64'd0);

        // Accept/load collision on the completion cycle of C
        got.delete(); ovr_count = 0;
        pl = 16'($urandom); pr = 16'($urandom);
        cl = 16'($urandom); cr = 16'($urandom);
        @(posedge clk);
        #1 dif.out_ready = 1'b0;
        sync_phase();
        send_frame(pl, pr);
        send_slot(1'b0, cl, SLOT);
        for (int i = 0; i < DW; i++) begin
            if (i == 0) bclk_bit(1'b1, 1'($urandom));
            else bclk_bit(1'b1, cr[DW-i]);
        end
        lrck = 1'b1;
        adcdat = cr[0];
        #HALF_B bclk = 1'b1;
        t_rise = $time;
        @(posedge clk);
        @(posedge clk);
        #1 dif.out_ready = 1'b1;
        @(posedge clk);
        #1 dif.out_ready = 1'b0;
        #(t_rise + HALF_B - $time) bclk = 1'b0;
        for (int i = DW + 1; i < SLOT; i++) bclk_bit(1'b1, 1'($urandom));
        settle();
        chk("coll_overrun", 64'(ovr_count), 64'd0);
        chk("coll_valid", 64'(dif.out_valid), 64'd1);
        chk("coll_data", 64'({dif.out_left, dif.out_right}), 64'({cl, cr}));
        chk("coll_count", 64'(got.size()), 64'd1);
        if (got.size() > 0) chk("coll_first", 64'(got[0]), 64'({pl, pr}));
        @(posedge clk);
        #1 dif.out_ready = 1'b1;
        settle();
        chk("coll_drain_count", 64'(got.size()), 64'd2);
        if (got.size() > 1) chk("coll_second", 64'(got[1]), 64'({cl, cr}));

        // Short slot: LRCK toggles after 8 left data bits
        got.delete(); ferr_count = 0;
        yl = 16'($urandom) | 16'h8001; yr = 16'($urandom) | 16'h0101;
        sync_phase();
        send_slot(1'b0, 16'($urandom), 1 + 8);
        send_slot(1'b1, 16'($urandom), SLOT);
        send_frame(yl, yr);
        settle();
        chk("short_frame_err", 64'(ferr_count), 64'd1);
        chk("short_count", 64'(got.size()), 64'd1);
        if (got.size() > 0) chk("short_data", 64'(got[0]), 64'({yl, yr}));

        // Reset mid-capture during the left-slot MSBs
        got.delete();
        xl = 16'($urandom); xr = 16'($urandom);
        pl = 16'($urandom); pr = 16'($urandom);
        sync_phase();
        fork
            begin
                send_frame(xl, xr);
                send_frame(pl, pr);
            end
            begin
                #(2 * HALF_B * 5);
                @(posedge clk);
                #1 resetn = 1'b0;
                @(posedge clk);
                @(posedge clk);
                #1;
                chk("mrst_valid", 64'(dif.out_valid), 64'd0);
                chk("mrst_left", 64'(dif.out_left), 64'd0);
                chk("mrst_right", 64'(dif.out_right), 64'd0);
                chk("mrst_overrun", 64'(overrun), 64'd0);
                chk("mrst_frame_err", 64'(frame_err), 64'd0);
                chk("mrst_ovr_cnt", 64'(overrun_cnt), 64'd0);
                resetn = 1'b1;
            end
        join
        settle();
        chk("mrst_count", 64'(got.size()), 64'd1);
        if (got.size() > 0) chk("mrst_data", 64'(got[0]), 64'({pl, pr}));

        // Randomized frames against a queue of expected frames
        got.delete(); exp_q.delete(); ferr_count = 0; ovr_count = 0;
        sync_phase();
        for (int f = 0; f < 6; f++) begin
            xl = 16'($urandom); xr = 16'($urandom);
            exp_q.push_back({xl, xr});
            send_frame(xl, xr);
        end
        settle();
        chk("rand_count", 64'(got.size()), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k < got.size()) chk("rand_data", 64'(got[k]), 64'(exp_q[k]));
        end
        chk("rand_frame_err", 64'(ferr_count), 64'd0);
        chk("rand_overrun", 64'(ovr_count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
